// File: rtl/press_sequence_classifier.sv
// press_sequence_classifier: groups debounced button pulses into multi-tap
// events and presents the press count on a valid/ready output.
//
// Ports:
//   clk               system clock
//   async_rst_n       asynchronous active-low reset
//   clk_en            global enable; state only updates on enabled edges
//   press_pulse       debounced single-cycle press pulse
//   press_count_ready consumer accepts the event
//   press_count_valid event available (registered)
//   press_count       presses in the event, 1..Max_Press_Count (registered)
//   dropped_count     pulses dropped while holding an event, saturating at
//                     255; present only with PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
module press_sequence_classifier #(
    parameter int unsigned Gap_Window_Cycles = 10_500_000,
    parameter int unsigned Max_Press_Count   = 4,
    localparam int unsigned Count_Width = $clog2(Max_Press_Count + 1),
    localparam int unsigned Timer_Width = $clog2(Gap_Window_Cycles)
) (
    input  logic                   clk,
    input  logic                   async_rst_n,
    input  logic                   clk_en,
    input  logic                   press_pulse,
    input  logic                   press_count_ready,
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
    output logic [7:0]             dropped_count,
`endif
    output logic                   press_count_valid,
    output logic [Count_Width-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [Timer_Width-1:0] TimerLast =
        Timer_Width'(Gap_Window_Cycles - 1);
    localparam logic [Count_Width-1:0] CountMax =
        Count_Width'(Max_Press_Count);
    localparam logic [Count_Width-1:0] CountOne = Count_Width'(1);

    state_t                 state_q, state_d;
    logic [Count_Width-1:0] count_q, count_d;
    logic [Timer_Width-1:0] timer_q, timer_d;
    logic                   valid_q, valid_d;
    logic [Count_Width-1:0] pcount_q, pcount_d;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
    logic [7:0]             drop_q, drop_d;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        timer_d  = timer_q;
        valid_d  = valid_q;
        pcount_d = pcount_q;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
        drop_d   = drop_q;
`endif
        if (clk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (press_pulse) begin
                        state_d = COLLECT;
                        count_d = CountOne;
                        timer_d = '0;
                    end
                end
                COLLECT: begin
                    // a pulse on the expiry edge extends the sequence
                    if (press_pulse) begin
                        if (count_q != CountMax)
                            count_d = count_q + CountOne;
                        timer_d = '0;
                    end else if (timer_q == TimerLast) begin
                        state_d  = HOLD;
                        valid_d  = 1'b1;
                        pcount_d = count_q;
                    end else begin
                        timer_d = timer_q + Timer_Width'(1);
                    end
                end
                HOLD: begin
                    if (press_count_ready) begin
                        valid_d = 1'b0;
                        // a press on the acceptance edge opens a new sequence
                        if (press_pulse) begin
                            state_d = COLLECT;
                            count_d = CountOne;
                            timer_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
                    else if (press_pulse && drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            timer_q  <= '0;
            valid_q  <= 1'b0;
            pcount_q <= '0;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
            drop_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            valid_q  <= valid_d;
            pcount_q <= pcount_d;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
            drop_q   <= drop_d;
`endif
        end
    end

    assign press_count_valid = valid_q;
    assign press_count       = pcount_q;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
    assign dropped_count     = drop_q;
`endif

endmodule

// File: tb/tb_press_sequence_classifier.sv
// tb_press_sequence_classifier: directed vector bench for the press
// sequence classifier (gap window 8, max count 4).
module tb_press_sequence_classifier;

    logic       clk;
    logic       async_rst_n;
    logic       clk_en;
    logic       press_pulse;
    logic       press_count_ready;
    logic       press_count_valid;
    logic [2:0] press_count;
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
    logic [7:0] dropped_count;
`endif

    int checks = 0;
    int errors = 0;

    press_sequence_classifier #(
        .Gap_Window_Cycles(8),
        .Max_Press_Count(4)
    ) dut (
        .clk(clk),
        .async_rst_n(async_rst_n),
        .clk_en(clk_en),
        .press_pulse(press_pulse),
        .press_count_ready(press_count_ready),
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
        .dropped_count(dropped_count),
`endif
        .press_count_valid(press_count_valid),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       pulse;
        logic       ready;
        logic       ev;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, input logic p,
                                input logic r, input logic ev,
                                input logic [2:0] ec);
        vec_t v;
        v.en = en; v.pulse = p; v.ready = r; v.ev = ev; v.ec = ec;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // drive one edge's inputs, then sample 1 ns after the edge
    task automatic apply(input logic en, input logic p, input logic r,
                         input logic ev, input logic [2:0] ec,
                         input string tag);
        clk_en = en;
        press_pulse = p;
        press_count_ready = r;
        @(posedge clk);
        #1;
        chk({tag, " valid"}, int'(press_count_valid), int'(ev));
        if (ev)
            chk({tag, " count"}, int'(press_count), int'(ec));
    endtask

    initial begin
        // single press, ready high: valid for exactly one cycle
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 0);
        add(1, 0, 1, 1, 1);
        add(1, 0, 1, 0, 0);

        // three presses, third lands on the would-be expiry edge
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 1, 0, 0);
        add(1, 0, 1, 1, 3);
        add(1, 0, 1, 0, 0);

        // six presses saturate at 4, then 20 cycles of back-pressure
        for (int k = 0; k < 6; k++) begin
            add(1, 1, 0, 0, 0);
            add(1, 0, 0, 0, 0);
            add(1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 4);
        for (int i = 0; i < 20; i++) add(1, 0, 0, 1, 4);
        add(1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0);

        // drops in HOLD, then a press on the acceptance edge
        add(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1);
        add(1, 1, 0, 1, 1);
        add(1, 1, 0, 1, 1);
        add(1, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1);
        add(1, 0, 1, 0, 0);

        // clk_en every 4th cycle; ready and pulses ignored when disabled
        add(1, 1, 0, 0, 0);
        for (int j = 1; j <= 8; j++) begin
            for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0);
            add(1, 0, 0, (j == 8), 1);
        end
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 1);
        add(1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0);

        async_rst_n = 1'b0;
        clk_en = 1'b0;
        press_pulse = 1'b0;
        press_count_ready = 1'b0;
        #2;
        chk("reset valid", int'(press_count_valid), 0);
        chk("reset count", int'(press_count), 0);
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
        chk("reset dropped", int'(dropped_count), 0);
`endif
        #10;
        async_rst_n = 1'b1;

        foreach (tbl[i])
            apply(tbl[i].en, tbl[i].pulse, tbl[i].ready, tbl[i].ev,
                  tbl[i].ec, $sformatf("vec%0d", i));

`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
        chk("dropped after table", int'(dropped_count), 2);
`endif

        // async reset mid-COLLECT
        apply(1, 1, 0, 0, 0, "c_press");
        for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, "c_idle");
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("rst_collect valid", int'(press_count_valid), 0);
        chk("rst_collect count", int'(press_count), 0);
        #2;
        async_rst_n = 1'b1;

        // async reset mid-HOLD
        apply(1, 1, 0, 0, 0, "h_press");
        for (int i = 0; i < 7; i++) apply(1, 0, 0, 0, 0, "h_idle");
        apply(1, 0, 0, 1, 1, "h_hold");
        apply(1, 1, 0, 1, 1, "h_drop");
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("rst_hold valid", int'(press_count_valid), 0);
        chk("rst_hold count", int'(press_count), 0);
`ifdef PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN
        chk("rst_hold dropped", int'(dropped_count), 0);
`endif
        #2;
        async_rst_n = 1'b1;

        // fresh single press after release
        apply(1, 1, 1, 0, 0, "f_press");
        for (int i = 0; i < 7; i++) apply(1, 0, 1, 0, 0, "f_idle");
        apply(1, 0, 1, 1, 1, "f_event");
        apply(1, 0, 1, 0, 0, "f_done");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/press_sequence_classifier.md
# press_sequence_classifier

Consumes single-cycle debounced button pulses from the monostable debouncer and groups presses separated by less than a configurable gap into one event. When the gap expires it presents the press count (single, double, triple, … saturating) on a valid/ready output. It sits between the debouncer and the UI/command logic, so a button can carry multi-tap commands.

## Interface
- Gap_Window_Cycles, default 10_500_000 (0.3 s @ 35 MHz): enabled cycles of silence that close a sequence; must be ≥ 2.
- Max_Press_Count, default 4: saturation value of the count; must be ≥ 1.
- Count_Width, derived, `$clog2(Max_Press_Count+1)`: width of `press_count`.
- Timer_Width, derived, `$clog2(Gap_Window_Cycles)`: width of the gap timer.
- clk  input  1  system clock; one clock for the whole block.
- async_rst_n  input  1  reset, asynchronous, active-low.
- clk_en  input  1  global clock enable; all state updates are qualified by it.
- press_pulse  input  1  debounced pulse, active high, normally 1 cycle wide.
- press_count_ready  input  1  consumer accepts the event.
- press_count_valid  output  1  event available.
- press_count  output  Count_Width  number of presses in the event, 1..Max_Press_Count.
- dropped_count  output  8  only when the macro is defined; see Configuration.

## Operation
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - On enabled edge with `press_pulse`: count=1, timer=0, go to COLLECT.
- COLLECT, per enabled edge:
  - `press_pulse`: count = min(count+1, Max_Press_Count), timer=0.
  - else timer == Gap_Window_Cycles-1: go to HOLD; assert valid.
  - else timer+1.
  - A pulse has priority over expiry on the same edge.
- HOLD:
  - `press_count_valid`=1; `press_count` is stable until the transfer completes.
  - Transfer completes on an enabled edge with valid && ready. Next state is IDLE, or COLLECT with count=1/timer=0 if `press_pulse` is high on that same edge, so that press is not lost.
  - Pulses on any other HOLD edge are dropped.
- Valid never deasserts without a transfer, except on reset. `press_count` is held at its last value after a transfer, don't-care while valid=0.
- Count arithmetic is saturating, never wraps. The timer resets on every pulse and never exceeds Gap_Window_Cycles-1.
- Reset (async assert, at any time including mid-sequence or mid-HOLD):
  - state IDLE, count 0, timer 0, `press_count_valid`=0, `press_count`=0, `dropped_count`=0.
  - Any in-flight sequence is discarded.
- Deassertion of `async_rst_n` is assumed synchronised upstream. The first enabled edge after release may capture a pulse.

## Timing
- Latency: when the last pulse of a sequence is captured at enabled edge E and clk_en is continuously high, `press_count_valid` rises after edge E+Gap_Window_Cycles.
- With clk_en gated, latency counts enabled edges only.
- Cycles with clk_en=0 freeze state, timer, count and handshake; ready is ignored on such edges.
- Outputs are registered; no combinational path from any input to any output.
- Throughput: one event per sequence. Back-to-back HOLD→COLLECT on the acceptance edge costs zero cycles.

## Configuration
- Macro: `PRESS_SEQUENCE_CLASSIFIER_DROP_COUNT_EN`.
- Defined:
  - adds output `dropped_count[7:0]`, a saturating (stops at 255) counter of pulses dropped in HOLD.
  - Cleared only by reset; updated on enabled edges only.
- Undefined: the port and counter do not exist; dropped pulses are silently ignored. All other behaviour is identical.

## Test plan
Benches use Gap_Window_Cycles=8, Max_Press_Count=4, clk_en=1 unless stated.
- Single press: pulse at edge 10, ready=1 → valid high for exactly 1 cycle after edge 18, `press_count`=1.
- Double press plus gap-boundary priority: pulses at edges 10 and 17, then a third at edge 25 (the would-be expiry edge) → one event, count=3, valid after edge 33.
- Saturation and back-pressure: 6 pulses spaced 3 cycles apart with ready=0 → count=4; valid held with stable count for 20 cycles. Ready raised → single transfer, then valid=0.
- HOLD drop and acceptance-edge capture: in HOLD with ready=0, pulses on 2 edges are dropped (`dropped_count`=2 with macro). A pulse coincident with the ready edge starts a new sequence, yielding count=1 eight cycles later.
- clk_en gating: clk_en high every 4th cycle, pulse on an enabled edge → valid after the 8th subsequent enabled edge. Ready on disabled edges is ignored.
- Async reset mid-COLLECT and mid-HOLD: all outputs 0 immediately, without a clock edge. After release, a fresh single press yields count=1.
